stos_wywolan_ster: RTL and testbench
====================================

Name: stos_wywolan_ster

Overview:
- Call/return controller sitting directly upstream of the 8-bit hardware stack; it is the only master of the stack's push/pop/data_in.
- On CALL it pushes the 16-bit return address as two bytes, low byte first, then loads the PC with the call target.
- On RET it pops two bytes, high byte first, reassembles them and loads the PC.
- Keeps its own occupancy count so a CALL never half-fits and a RET never half-empties the stack.

Parameters:
- DATA_W, 8, stack word width; must match the stack's data width.
- PC_W, 16, program counter width; fixed at 2*DATA_W, elaborated with an assertion.
- STOS_ROZM, 32, stack depth in words; must match the stack's depth.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  1  CALL request from decoder; sampled only in IDLE.
- ret_req  in  1  RET request from decoder; sampled only in IDLE.
- pc_in  in  PC_W  address of the CALL instruction.
- cel_in  in  PC_W  CALL target address.
- pc_out  out  PC_W  new PC value; holds its last value between loads.
- pc_load  out  1  one-cycle strobe: PC must take pc_out.
- done  out  1  one-cycle strobe: operation completed (same cycle as pc_load).
- busy  out  1  high whenever state is not IDLE.
- err_przepeln  out  1  one-cycle strobe: CALL rejected, stack would overflow.
- err_niedomiar  out  1  one-cycle strobe: RET rejected, stack would underflow.
- st_push  out  1  to stack push.
- st_pop  out  1  to stack pop.
- st_dane_wy  out  DATA_W  to stack data_in.
- st_dane_we  in  DATA_W  from stack data_out; combinational, valid in the same cycle as st_pop.
- st_full  in  1  stack full flag.
- st_empty  in  1  stack empty flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, occupancy=0, pc_out=0, and every strobe, busy, st_push and st_pop at 0. The stack shares rst, so both sides restart empty. A reset mid-operation abandons the operation with no pc_load.
- States: IDLE, PUSH_LO, PUSH_HI, POP_HI, POP_LO, FIN.
- st_push, st_pop and st_dane_wy are decoded from the state only (Moore). Strobes are registered.
- IDLE accepting a CALL (call_req=1):
  - If occupancy > STOS_ROZM-2 or st_full=1: err_przepeln=1 next cycle, stay in IDLE, no push.
  - Otherwise latch powrot = pc_in+1 (mod 2^PC_W; 0xFFFF -> 0x0000) and cel = cel_in, then go to PUSH_LO.
- IDLE accepting a RET (ret_req=1, call_req=0):
  - If occupancy < 2 or st_empty=1: err_niedomiar=1 next cycle, stay in IDLE.
  - Otherwise go to POP_HI.
- call_req and ret_req both high: CALL has priority and the RET is dropped.
- Requests arriving while busy=1 are ignored, not queued.
- PUSH_LO: st_push=1, st_dane_wy=powrot[7:0], occupancy+1, go to PUSH_HI.
- PUSH_HI: st_push=1, st_dane_wy=powrot[15:8], occupancy+1, set pc_out=cel, go to FIN.
- POP_HI: st_pop=1, register st_dane_we into hi, occupancy-1, go to POP_LO.
- POP_LO: st_pop=1, register st_dane_we into lo, occupancy-1, set pc_out={hi, st_dane_we}, go to FIN.
- FIN: pc_load=1, done=1, busy=1, return to IDLE.
- Latency: request sampled at edge N; pc_load and done are high in cycle N+3. The next request is accepted at edge N+4, so back-to-back throughput is one operation per 4 cycles.
- st_dane_wy is 0 outside the push states. st_push and st_pop are never high together.
- Occupancy counter is $clog2(STOS_ROZM+1) bits wide and stays within 0..STOS_ROZM.

Decomposition:
- Package stos_pkg holds:
  - typedef enum stos_ster_stan_t for the six states;
  - localparams DATA_W_DEF=8, PC_W_DEF=16, STOS_ROZM_DEF=32;
  - the bytes-per-address constant (2).
- Single flat module; no sub-module is natural.
- The bench instantiates stos_wywolan_ster together with the stack for integration checks.

Test Plan:
- CALL: pc_in=0x1234, cel_in=0x4000 -> stack writes 0x35 then 0x12 on consecutive cycles; pc_out=0x4000 with pc_load=1 and done=1 exactly 3 cycles after the request; occupancy=2.
- Follow that with RET -> two pops; pc_out=0x1235, pc_load=1 at +3 cycles; occupancy=0 and stack empty=1.
- Nested CALLs: 0x0100->0x0200, then 0x0200->0x0300, then two RETs -> pc_out=0x0201, then 0x0101 (LIFO order preserved).
- Overflow: 16 CALLs fill 32 words; 17th CALL -> err_przepeln pulses once, no st_push, busy stays 0. RET on an empty stack -> err_niedomiar pulses, no st_pop.
- Boundaries: pc_in=0xFFFF -> pushes 0x00 then 0x00. call_req and ret_req high together in IDLE -> CALL executed. ret_req pulsed during PUSH_HI -> ignored.
- Reset: rst asserted asynchronously during POP_HI (mid-clock) -> all outputs 0 immediately, no pc_load afterwards, occupancy=0. A following CALL behaves as on a fresh stack.

Source files
------------

// File: rtl/stos_pkg.sv
// Shared types and defaults for the call/return controller that drives the hardware stack.
package stos_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PUSH_LO,
      PUSH_HI,
      POP_HI,
      POP_LO,
      FIN
   } stos_ster_stan_t;

   localparam int DATA_W_DEF     = 8;
   localparam int PC_W_DEF       = 16;
   localparam int STOS_ROZM_DEF  = 32;
   localparam int BAJTY_NA_ADRES = 2;

endpackage

// File: rtl/stos_wywolan_ster.sv
// CALL/RET sequencer: pushes the return address low byte first, pops it high byte first,
// and tracks stack occupancy so an address is never split across a full or empty stack.
module stos_wywolan_ster
   import stos_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int PC_W      = PC_W_DEF,
   parameter int STOS_ROZM = STOS_ROZM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [PC_W-1:0]   cel_in,
   output logic [PC_W-1:0]   pc_out,
   output logic              pc_load,
   output logic              done,
   output logic              busy,
   output logic              err_przepeln,
   output logic              err_niedomiar,
   output logic              st_push,
   output logic              st_pop,
   output logic [DATA_W-1:0] st_dane_wy,
   input  logic [DATA_W-1:0] st_dane_we,
   input  logic              st_full,
   input  logic              st_empty
);

   localparam int OCC_W = $clog2(STOS_ROZM + 1);
   localparam logic [OCC_W-1:0] OCC_MAX_CALL = OCC_W'(STOS_ROZM - BAJTY_NA_ADRES);
   localparam logic [OCC_W-1:0] OCC_MIN_RET  = OCC_W'(BAJTY_NA_ADRES);

   if (PC_W != BAJTY_NA_ADRES * DATA_W) begin : g_pc_w_check
      $error("stos_wywolan_ster: PC_W must be exactly two stack words wide");
   end

   stos_ster_stan_t   state, state_nxt;
   logic [PC_W-1:0]   powrot;
   logic [PC_W-1:0]   cel;
   logic [DATA_W-1:0] hi;
   logic [OCC_W-1:0]  occ;
   logic              call_ok;
   logic              ret_ok;

   // A CALL needs room for both bytes, a RET needs both bytes present.
   assign call_ok = (occ <= OCC_MAX_CALL) && !st_full;
   assign ret_ok  = (occ >= OCC_MIN_RET) && !st_empty;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (call_req) begin
               if (call_ok) state_nxt = PUSH_LO;
            end else if (ret_req) begin
               if (ret_ok) state_nxt = POP_HI;
            end
         end
         PUSH_LO: state_nxt = PUSH_HI;
         PUSH_HI: state_nxt = FIN;
         POP_HI:  state_nxt = POP_LO;
         POP_LO:  state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      st_push    = 1'b0;
      st_pop     = 1'b0;
      st_dane_wy = '0;
      unique case (state)
         PUSH_LO: begin
            st_push    = 1'b1;
            st_dane_wy = powrot[DATA_W-1:0];
         end
         PUSH_HI: begin
            st_push    = 1'b1;
            st_dane_wy = powrot[PC_W-1:DATA_W];
         end
         POP_HI, POP_LO: st_pop = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ           <= '0;
         pc_out        <= '0;
         powrot        <= '0;
         cel           <= '0;
         hi            <= '0;
         pc_load       <= 1'b0;
         done          <= 1'b0;
         err_przepeln  <= 1'b0;
         err_niedomiar <= 1'b0;
      end else begin
         pc_load       <= (state_nxt == FIN);
         done          <= (state_nxt == FIN);
         err_przepeln  <= (state == IDLE) && call_req && !call_ok;
         err_niedomiar <= (state == IDLE) && !call_req && ret_req && !ret_ok;

         if ((state == IDLE) && call_req && call_ok) begin
            powrot <= pc_in + PC_W'(1);
            cel    <= cel_in;
         end

         unique case (state)
            PUSH_LO: occ <= occ + OCC_W'(1);
            PUSH_HI: begin
               occ    <= occ + OCC_W'(1);
               pc_out <= cel;
            end
            POP_HI: begin
               hi  <= st_dane_we;
               occ <= occ - OCC_W'(1);
            end
            POP_LO: begin
               occ    <= occ - OCC_W'(1);
               pc_out <= {hi, st_dane_we};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stos_wywolan_ster.sv
// Directed bench for stos_wywolan_ster wired to a small behavioural 8-bit x 32 stack.
module tb_stos_wywolan_ster;

   logic        clk = 1'b0;
   logic        rst;
   logic        call_req, ret_req;
   logic [15:0] pc_in, cel_in, pc_out;
   logic        pc_load, done, busy, err_przepeln, err_niedomiar;
   logic        st_push, st_pop, st_full, st_empty;
   logic [7:0]  st_dane_wy, st_dane_we;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sm_mem [0:31];
   int         sm_sp;

   always #5 clk = ~clk;

   stos_wywolan_ster dut (
      .clk           (clk),
      .rst           (rst),
      .call_req      (call_req),
      .ret_req       (ret_req),
      .pc_in         (pc_in),
      .cel_in        (cel_in),
      .pc_out        (pc_out),
      .pc_load       (pc_load),
      .done          (done),
      .busy          (busy),
      .err_przepeln  (err_przepeln),
      .err_niedomiar (err_niedomiar),
      .st_push       (st_push),
      .st_pop        (st_pop),
      .st_dane_wy    (st_dane_wy),
      .st_dane_we    (st_dane_we),
      .st_full       (st_full),
      .st_empty      (st_empty)
   );

   // Reference stack: push writes at sp, pop exposes mem[sp-1] combinationally.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sm_sp <= 0;
      end else if (st_push && sm_sp < 32) begin
         sm_mem[sm_sp] <= st_dane_wy;
         sm_sp         <= sm_sp + 1;
      end else if (st_pop && sm_sp > 0) begin
         sm_sp <= sm_sp - 1;
      end
   end

   assign st_dane_we = (sm_sp > 0) ? sm_mem[sm_sp-1] : 8'h00;
   assign st_full    = (sm_sp == 32);
   assign st_empty   = (sm_sp == 0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_call(input logic [15:0] pc, input logic [15:0] cel,
                          input logic [7:0] lo, input logic [7:0] hi,
                          input logic both, input logic mid, input string tag);
      pc_in    = pc;
      cel_in   = cel;
      call_req = 1'b1;
      ret_req  = both;
      @(posedge clk); #1;
      call_req = 1'b0;
      ret_req  = 1'b0;
      check({tag, "/push_lo"}, st_push, 1);
      check({tag, "/data_lo"}, st_dane_wy, lo);
      check({tag, "/no_pop_lo"}, st_pop, 0);
      check({tag, "/busy"}, busy, 1);
      @(posedge clk); #1;
      check({tag, "/push_hi"}, st_push, 1);
      check({tag, "/data_hi"}, st_dane_wy, hi);
      if (mid) ret_req = 1'b1;
      @(posedge clk); #1;
      ret_req = 1'b0;
      check({tag, "/pc_load"}, pc_load, 1);
      check({tag, "/done"}, done, 1);
      check({tag, "/pc_out"}, pc_out, cel);
      check({tag, "/fin_no_push"}, st_push, 0);
      check({tag, "/fin_data0"}, st_dane_wy, 0);
      @(posedge clk); #1;
      check({tag, "/idle_busy"}, busy, 0);
      check({tag, "/idle_pc_load"}, pc_load, 0);
      check({tag, "/idle_no_pop"}, st_pop, 0);
   endtask

   task automatic do_ret(input logic [15:0] exp_pc, input string tag);
      ret_req = 1'b1;
      @(posedge clk); #1;
      ret_req = 1'b0;
      check({tag, "/pop_hi"}, st_pop, 1);
      check({tag, "/no_push"}, st_push, 0);
      @(posedge clk); #1;
      check({tag, "/pop_lo"}, st_pop, 1);
      @(posedge clk); #1;
      check({tag, "/pc_load"}, pc_load, 1);
      check({tag, "/done"}, done, 1);
      check({tag, "/pc_out"}, pc_out, exp_pc);
      @(posedge clk); #1;
      check({tag, "/idle_busy"}, busy, 0);
      check({tag, "/idle_done"}, done, 0);
   endtask

   initial begin
      rst      = 1'b1;
      call_req = 1'b0;
      ret_req  = 1'b0;
      pc_in    = '0;
      cel_in   = '0;
      #1;
      check("rst/pc_out", pc_out, 0);
      check("rst/pc_load", pc_load, 0);
      check("rst/busy", busy, 0);
      check("rst/push", st_push, 0);
      check("rst/pop", st_pop, 0);
      check("rst/errs", {err_przepeln, err_niedomiar}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic CALL then RET
      do_call(16'h1234, 16'h4000, 8'h35, 8'h12, 1'b0, 1'b0, "call1");
      check("call1/stack_lo", sm_mem[0], 8'h35);
      check("call1/stack_hi", sm_mem[1], 8'h12);
      check("call1/occ", dut.occ, 2);
      check("call1/sp", sm_sp, 2);
      do_ret(16'h1235, "ret1");
      check("ret1/occ", dut.occ, 0);
      check("ret1/empty", st_empty, 1);

      // Nested calls return in LIFO order
      do_call(16'h0100, 16'h0200, 8'h01, 8'h01, 1'b0, 1'b0, "nest1");
      do_call(16'h0200, 16'h0300, 8'h01, 8'h02, 1'b0, 1'b0, "nest2");
      do_ret(16'h0201, "nret2");
      do_ret(16'h0101, "nret1");

      // Fill all 32 words with 16 calls
      for (int i = 0; i < 16; i++) begin
         do_call({i[7:0], 8'h00}, 16'h8000 | 16'(i), 8'h01, i[7:0], 1'b0, 1'b0, "fill");
      end
      check("fill/sp", sm_sp, 32);
      check("fill/occ", dut.occ, 32);

      // 17th call is rejected
      pc_in    = 16'h7777;
      cel_in   = 16'h1111;
      call_req = 1'b1;
      @(posedge clk); #1;
      call_req = 1'b0;
      check("ovf/err", err_przepeln, 1);
      check("ovf/no_push", st_push, 0);
      check("ovf/busy", busy, 0);
      @(posedge clk); #1;
      check("ovf/err_once", err_przepeln, 0);
      check("ovf/busy2", busy, 0);
      check("ovf/sp", sm_sp, 32);
      check("ovf/pc_load", pc_load, 0);

      for (int i = 15; i >= 0; i--) begin
         do_ret({i[7:0], 8'h01}, "drain");
      end
      check("drain/empty", st_empty, 1);

      // RET on empty stack is rejected
      ret_req = 1'b1;
      @(posedge clk); #1;
      ret_req = 1'b0;
      check("udf/err", err_niedomiar, 1);
      check("udf/no_pop", st_pop, 0);
      check("udf/busy", busy, 0);
      @(posedge clk); #1;
      check("udf/err_once", err_niedomiar, 0);
      check("udf/occ", dut.occ, 0);

      // CALL wins over simultaneous RET; RET during PUSH_HI is ignored
      do_call(16'h0ABC, 16'h0DEF, 8'hBD, 8'h0A, 1'b1, 1'b1, "both");
      check("both/sp", sm_sp, 2);
      check("both/no_err", err_niedomiar, 0);
      do_ret(16'h0ABD, "both_ret");

      // Return address wraps from 0xFFFF
      do_call(16'hFFFF, 16'h0010, 8'h00, 8'h00, 1'b0, 1'b0, "wrap");
      do_ret(16'h0000, "wrap_ret");

      // Asynchronous reset mid-POP_HI
      do_call(16'h2000, 16'h3000, 8'h01, 8'h20, 1'b0, 1'b0, "pre_rst");
      ret_req = 1'b1;
      @(posedge clk); #1;
      ret_req = 1'b0;
      check("arst/in_pop", st_pop, 1);
      #3;
      rst = 1'b1;
      #1;
      check("arst/pop", st_pop, 0);
      check("arst/busy", busy, 0);
      check("arst/pc_out", pc_out, 0);
      check("arst/pc_load", pc_load, 0);
      check("arst/occ", dut.occ, 0);
      check("arst/empty", st_empty, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("arst/no_load", pc_load, 0);
      end

      do_call(16'h1234, 16'h4000, 8'h35, 8'h12, 1'b0, 1'b0, "fresh");
      check("fresh/sp", sm_sp, 2);
      check("fresh/occ", dut.occ, 2);
      do_ret(16'h1235, "fresh_ret");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
